// File: rtl/bank_rr_arbiter.sv
// Round-robin arbiter sharing one DEPTH x DW register bank between N_REQ requesters.
// Optional macro BANK_ADDR_ERR_EN adds a registered out-of-range error pulse (err).
module bank_rr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DEPTH     = 25,
    parameter int DW        = 9,
    parameter int AW        = 5,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         lock,
    input  logic [N_REQ-1:0]         we,
    input  logic [N_REQ*AW-1:0]      addr,
    input  logic [N_REQ*DW-1:0]      wdata,
    output logic [N_REQ-1:0]         gnt,
    output logic [DW-1:0]            rdata,
    output logic                     rvalid,
    output logic [$clog2(N_REQ)-1:0] rid,
`ifdef BANK_ADDR_ERR_EN
    output logic                     err,
`endif
    output logic                     busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] owner;
    logic [CW-1:0] cnt;
    logic [DW-1:0] bank [DEPTH];

    logic [IW-1:0] pick;
    logic [IW-1:0] cand;
    logic          any;

    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata;
    logic          o_req;
    logic          o_lock;
    logic          o_we;
    logic          in_range;
    logic          live;

    // Scan downward so the nearest requester after ptr is the last to win.
    always_comb begin
        pick = '0;
        cand = '0;
        any  = 1'b0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = IW'((int'(ptr) + i) % N_REQ);
            if (req[cand]) begin
                pick = cand;
                any  = 1'b1;
            end
        end
    end

    assign o_addr   = addr[int'(owner)*AW +: AW];
    assign o_wdata  = wdata[int'(owner)*DW +: DW];
    assign o_req    = req[owner];
    assign o_lock   = lock[owner];
    assign o_we     = we[owner];
    assign in_range = (int'(o_addr) < DEPTH);
    assign live     = (state == GRANT) && o_req;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else if (live && o_we && in_range) begin
            bank[o_addr] <= o_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            gnt    <= '0;
            owner  <= '0;
            ptr    <= IW'(N_REQ - 1);
            cnt    <= '0;
            rvalid <= 1'b0;
            rdata  <= '0;
            rid    <= '0;
`ifdef BANK_ADDR_ERR_EN
            err    <= 1'b0;
`endif
        end else begin
            rvalid <= 1'b0;
`ifdef BANK_ADDR_ERR_EN
            err    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (any) begin
                        gnt   <= N_REQ'(1) << pick;
                        owner <= pick;
                        cnt   <= CW'(1);
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (o_req && !o_we) begin
                        rvalid <= 1'b1;
                        rid    <= owner;
                        rdata  <= in_range ? bank[o_addr] : '0;
                    end
`ifdef BANK_ADDR_ERR_EN
                    err <= o_req && !in_range;
`endif
                    ptr <= owner;
                    if (o_req && o_lock && (cnt < CW'(MAX_BURST))) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        gnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bank_rr_arbiter.sv
// Self-checking bench for bank_rr_arbiter: vector table, directed corner
// sequences and a randomized run against a behavioural reference model.
module tb_bank_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [3:0]  we;
    logic [19:0] addr;
    logic [35:0] wdata;
    logic [3:0]  gnt;
    logic [8:0]  rdata;
    logic        rvalid;
    logic [1:0]  rid;
    logic        busy;
`ifdef BANK_ADDR_ERR_EN
    logic        err;
`endif

    int checks = 0;
    int errors = 0;

    bank_rr_arbiter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .lock   (lock),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .rdata  (rdata),
        .rvalid (rvalid),
        .rid    (rid),
`ifdef BANK_ADDR_ERR_EN
        .err    (err),
`endif
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(logic [3:0] r, logic [3:0] l, logic [3:0] w,
                         logic [4:0] a, logic [8:0] d);
        req   = r;
        lock  = l;
        we    = w;
        addr  = {4{a}};
        wdata = {4{d}};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(4'h0, 4'h0, 4'h0, 5'd0, 9'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: owner < 0 means no requester holds the bank.
    int          m_owner;
    int          m_ptr;
    int          m_cnt;
    int          m_mem [25];
    logic [3:0]  e_gnt;
    bit          e_rv;
    bit          e_err;
    int          e_rd;
    int          e_rid;

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 3;
        m_cnt   = 0;
        foreach (m_mem[i]) m_mem[i] = 0;
        e_gnt = 4'h0;
        e_rv  = 1'b0;
        e_err = 1'b0;
        e_rd  = 0;
        e_rid = 0;
    endtask

    task automatic model_step();
        int k;
        int a;
        e_rv  = 1'b0;
        e_err = 1'b0;
        if (m_owner < 0) begin
            for (int i = 1; i <= 4; i++) begin
                k = (m_ptr + i) % 4;
                if (req[k]) begin
                    m_owner = k;
                    m_cnt   = 1;
                    e_gnt   = 4'h0;
                    e_gnt[k] = 1'b1;
                    break;
                end
            end
        end else begin
            k = m_owner;
            a = int'(addr[k*5 +: 5]);
            if (req[k]) begin
                e_err = (a >= 25);
                if (we[k]) begin
                    if (a < 25) m_mem[a] = int'(wdata[k*9 +: 9]);
                end else begin
                    e_rv  = 1'b1;
                    e_rid = k;
                    e_rd  = (a < 25) ? m_mem[a] : 0;
                end
            end
            m_ptr = k;
            if (req[k] && lock[k] && m_cnt < 4) begin
                m_cnt++;
            end else begin
                m_owner = -1;
                e_gnt   = 4'h0;
            end
        end
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] r;
        logic [3:0] l;
        logic [3:0] w;
        logic [4:0] a;
        logic [8:0] d;
        logic [3:0] eg;
        bit         ev;
        logic [8:0] ed;
        logic [1:0] eid;
    } vec_t;

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{0, 4'h1, 4'h0, 4'h1, 5'd3, 9'h1A5, 4'h1, 0, 9'h000, 2'd0};
        tbl[1]  = '{0, 4'h1, 4'h0, 4'h1, 5'd3, 9'h1A5, 4'h0, 0, 9'h000, 2'd0};
        tbl[2]  = '{0, 4'h1, 4'h0, 4'h0, 5'd3, 9'h000, 4'h1, 0, 9'h000, 2'd0};
        tbl[3]  = '{0, 4'h1, 4'h0, 4'h0, 5'd3, 9'h000, 4'h0, 1, 9'h1A5, 2'd0};
        tbl[4]  = '{1, 4'hF, 4'h0, 4'h0, 5'd3, 9'h000, 4'h1, 0, 9'h000, 2'd0};
        tbl[5]  = '{0, 4'hF, 4'h0, 4'h0, 5'd3, 9'h000, 4'h0, 1, 9'h000, 2'd0};
        tbl[6]  = '{0, 4'hF, 4'h0, 4'h0, 5'd3, 9'h000, 4'h2, 0, 9'h000, 2'd0};
        tbl[7]  = '{0, 4'hF, 4'h0, 4'h0, 5'd3, 9'h000, 4'h0, 1, 9'h000, 2'd1};
        tbl[8]  = '{0, 4'hF, 4'h0, 4'h0, 5'd3, 9'h000, 4'h4, 0, 9'h000, 2'd0};
        tbl[9]  = '{0, 4'hF, 4'h0, 4'h0, 5'd3, 9'h000, 4'h0, 1, 9'h000, 2'd2};
        tbl[10] = '{0, 4'hF, 4'h0, 4'h0, 5'd3, 9'h000, 4'h8, 0, 9'h000, 2'd0};
        tbl[11] = '{0, 4'hF, 4'h0, 4'h0, 5'd3, 9'h000, 4'h0, 1, 9'h000, 2'd3};
        tbl[12] = '{0, 4'hF, 4'h0, 4'h0, 5'd3, 9'h000, 4'h1, 0, 9'h000, 2'd0};
        tbl[13] = '{0, 4'hF, 4'h0, 4'h0, 5'd3, 9'h000, 4'h0, 1, 9'h000, 2'd0};

        rst_n = 1'b0;
        drive(4'h0, 4'h0, 4'h0, 5'd0, 9'h0);
        #12;
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_rvalid", 32'(rvalid), 32'h0);
        chk("reset_rdata", 32'(rdata), 32'h0);
        chk("reset_rid", 32'(rid), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
`ifdef BANK_ADDR_ERR_EN
        chk("reset_err", 32'(err), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Table: single write/read, then round-robin rotation after reset.
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].rst) do_reset();
            drive(tbl[i].r, tbl[i].l, tbl[i].w, tbl[i].a, tbl[i].d);
            tick();
            chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].eg));
            chk($sformatf("tbl%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_rdata", i), 32'(rdata), 32'(tbl[i].ed));
                chk($sformatf("tbl%0d_rid", i), 32'(rid), 32'(tbl[i].eid));
            end
        end

        // Locked burst capped at four grants, then one idle cycle.
        do_reset();
        drive(4'b0110, 4'b0010, 4'h0, 5'd0, 9'h0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("burst_gnt%0d", c), 32'(gnt), 32'h2);
            chk($sformatf("burst_busy%0d", c), 32'(busy), 32'h1);
            if (c > 0) chk($sformatf("burst_rv%0d", c), 32'(rvalid), 32'h1);
        end
        tick();
        chk("burst_idle_gnt", 32'(gnt), 32'h0);
        chk("burst_idle_rv", 32'(rvalid), 32'h1);
        tick();
        chk("burst_next_gnt", 32'(gnt), 32'h4);

        // Out-of-range write and reads.
        do_reset();
        drive(4'h1, 4'h0, 4'h1, 5'd25, 9'h0FF);
        tick();
        chk("oor_wr_gnt", 32'(gnt), 32'h1);
        tick();
        chk("oor_wr_rv", 32'(rvalid), 32'h0);
`ifdef BANK_ADDR_ERR_EN
        chk("oor_wr_err", 32'(err), 32'h1);
`endif
        for (int j = 0; j < 2; j++) begin
            drive(4'h1, 4'h0, 4'h0, (j == 0) ? 5'd25 : 5'd24, 9'h0);
            tick();
            chk($sformatf("oor_rd%0d_gnt", j), 32'(gnt), 32'h1);
            tick();
            chk($sformatf("oor_rd%0d_rv", j), 32'(rvalid), 32'h1);
            chk($sformatf("oor_rd%0d_data", j), 32'(rdata), 32'h0);
`ifdef BANK_ADDR_ERR_EN
            chk($sformatf("oor_rd%0d_err", j), 32'(err), (j == 0) ? 32'h1 : 32'h0);
`endif
        end

        // Reset in the middle of a grant.
        do_reset();
        drive(4'h1, 4'h0, 4'h1, 5'd7, 9'h055);
        tick();
        tick();
        drive(4'h8, 4'h0, 4'h0, 5'd7, 9'h0);
        tick();
        chk("rstmid_gnt_pre", 32'(gnt), 32'h8);
        rst_n = 1'b0;
        #1;
        chk("rstmid_gnt_drop", 32'(gnt), 32'h0);
        chk("rstmid_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b1001, 4'h0, 4'h0, 5'd7, 9'h0);
        tick();
        chk("rstmid_no_rv", 32'(rvalid), 32'h0);
        chk("rstmid_first", 32'(gnt), 32'h1);
        tick();
        chk("rstmid_rd_rv", 32'(rvalid), 32'h1);
        chk("rstmid_rd_data", 32'(rdata), 32'h0);
        chk("rstmid_rd_rid", 32'(rid), 32'h0);

        // Request dropped during its grant cycle.
        do_reset();
        drive(4'h1, 4'h0, 4'h1, 5'd5, 9'h0AA);
        tick();
        tick();
        drive(4'h4, 4'h0, 4'h4, 5'd5, 9'h133);
        tick();
        chk("cancel_gnt", 32'(gnt), 32'h4);
        drive(4'h0, 4'h0, 4'h4, 5'd5, 9'h133);
        tick();
        chk("cancel_gnt_off", 32'(gnt), 32'h0);
        chk("cancel_no_rv", 32'(rvalid), 32'h0);
        drive(4'b1011, 4'h0, 4'h0, 5'd5, 9'h0);
        tick();
        chk("cancel_ptr_gnt", 32'(gnt), 32'h8);
        tick();
        chk("cancel_rd_rv", 32'(rvalid), 32'h1);
        chk("cancel_rd_data", 32'(rdata), 32'h0AA);
        chk("cancel_rd_rid", 32'(rid), 32'h3);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int n = 0; n < 600; n++) begin
            req   = 4'($urandom_range(0, 15));
            lock  = 4'($urandom_range(0, 15));
            we    = 4'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++) begin
                addr[k*5 +: 5]  = ($urandom_range(0, 7) == 0) ?
                                  5'($urandom_range(25, 31)) :
                                  5'($urandom_range(0, 24));
                wdata[k*9 +: 9] = 9'($urandom);
            end
            model_step();
            tick();
            chk($sformatf("rnd%0d_gnt", n), 32'(gnt), 32'(e_gnt));
            chk($sformatf("rnd%0d_busy", n), 32'(busy), 32'(m_owner >= 0));
            chk($sformatf("rnd%0d_rv", n), 32'(rvalid), 32'(e_rv));
            if (e_rv) begin
                chk($sformatf("rnd%0d_rdata", n), 32'(rdata), 32'(e_rd));
                chk($sformatf("rnd%0d_rid", n), 32'(rid), 32'(e_rid));
            end
`ifdef BANK_ADDR_ERR_EN
            chk($sformatf("rnd%0d_err", n), 32'(err), 32'(e_err));
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
